// File: rtl/alu4_seq.sv
// alu4_seq: sequenced 4-bit ALU stage with valid/ready on both sides.
// Single-cycle logic/arithmetic ops, plus an optional 4-iteration
// shift-add unsigned multiplier. Presents an 8-bit result and C/Z/N/V flags.
module alu4_seq #(
  parameter bit MUL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       r,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] y,
  output logic       c,
  output logic       z,
  output logic       n,
  output logic       v
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_NOTA = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt_p0;
  logic [3:0]  mcand_p0;
  logic [3:0]  mplier_p0;
  logic [7:0]  acc_p0;
  logic [7:0]  part;
  logic [7:0]  mul_sum;
  logic        is_mul;
  logic        accept;
  logic        mul_last;
  logic [11:0] alu_res;

  // Single-cycle result packed as {y[7:0], c, z, n, v}. MUL only reaches
  // here when the multiplier is disabled, and then returns all zeros.
  function automatic logic [11:0] alu_eval(input logic [3:0] fa,
                                           input logic [3:0] fb,
                                           input logic [2:0] fop);
    logic [4:0] sum;
    logic [3:0] res;
    logic       fc;
    logic       fv;
    sum = 5'd0;
    res = 4'd0;
    fc  = 1'b0;
    fv  = 1'b0;
    case (fop)
      OP_ADD: begin
        sum = {1'b0, fa} + {1'b0, fb};
        res = sum[3:0];
        fc  = sum[4];
        fv  = (fa[3] == fb[3]) && (res[3] != fa[3]);
      end
      OP_SUB: begin
        sum = {1'b0, fa} - {1'b0, fb};
        res = sum[3:0];
        fc  = (fa >= fb);
        fv  = (fa[3] != fb[3]) && (res[3] != fa[3]);
      end
      OP_AND:  res = fa & fb;
      OP_OR:   res = fa | fb;
      OP_XOR:  res = fa ^ fb;
      OP_NAND: res = ~(fa & fb);
      OP_NOTA: res = ~fa;
      default: res = 4'd0;
    endcase
    if (fop == OP_MUL) begin
      return 12'd0;
    end
    return {4'd0, res, fc, (res == 4'd0), res[3], fv};
  endfunction

  // Multiplier result flags: carry marks a product above 15; n and v unused.
  function automatic logic [11:0] mul_flags(input logic [7:0] p);
    return {p, |p[7:4], (p == 8'h00), 1'b0, 1'b0};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign is_mul    = MUL_EN && (op == OP_MUL);
  assign accept    = (state == IDLE) && in_valid;
  assign mul_last  = (state == MUL) && (cnt_p0 == 2'd3);
  assign alu_res   = alu_eval(a, b, op);

  // Partial product for this iteration and the running accumulation.
  always_comb begin
    part    = 8'h00;
    if (mplier_p0[0]) begin
      part = {4'd0, mcand_p0} << cnt_p0;
    end
    mul_sum = acc_p0 + part;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (r) state <= IDLE;
    else   state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) state_nxt = is_mul ? MUL : DONE;
      end
      MUL: begin
        if (cnt_p0 == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Iteration counter: runs 0..3 while multiplying, parked at 0 otherwise.
  always_ff @(posedge clk) begin
    if (r)                  cnt_p0 <= 2'd0;
    else if (state == MUL)  cnt_p0 <= cnt_p0 + 2'd1;
    else                    cnt_p0 <= 2'd0;
  end

  // Multiplier datapath: load operands on accept, then shift-add.
  always_ff @(posedge clk) begin
    if (accept) begin
      mcand_p0  <= a;
      mplier_p0 <= b;
      acc_p0    <= 8'h00;
    end else if (state == MUL) begin
      acc_p0    <= mul_sum;
      mplier_p0 <= {1'b0, mplier_p0[3:1]};
    end
  end

  // Result/flag register: loaded on a single-cycle accept or the last
  // multiply iteration, held otherwise so DONE outputs stay stable.
  always_ff @(posedge clk) begin
    if (r) begin
      {y, c, z, n, v} <= 12'd0;
    end else if (accept && !is_mul) begin
      {y, c, z, n, v} <= alu_res;
    end else if (mul_last) begin
      {y, c, z, n, v} <= mul_flags(mul_sum);
    end
  end

endmodule
